snoop_bus_arbiter: RTL and testbench

Shared-bus arbiter and transaction sequencer for the three-processor MSI snooping system. It grants the single coherence bus to one requesting processor at a time, round-robin. For each granted transaction it broadcasts the miss/invalidate message to the receptors, collects any snoop write-back, and drives the memory write-back and memory read. It returns a completion pulse plus fill data to the emitter.

---
 rtl/snoop_bus_arbiter.sv | 178 +++++++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter: round-robin owner of the MSI coherence bus that sequences
// broadcast, snoop collection, write-back and memory fill for three processors.
module snoop_bus_arbiter #(
  parameter int SNOOP_CYCLES = 2,
  parameter int MEM_LATENCY  = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic [5:0] msg_in,
  input  logic [8:0] addr_in,
  input  logic [2:0] snoop_wb,
  input  logic [8:0] snoop_wb_data,
  input  logic [2:0] mem_rdata,
  output logic [2:0] grant,
  output logic       bus_valid,
  output logic [1:0] bus_msg,
  output logic [2:0] bus_addr,
  output logic [1:0] bus_src,
  output logic       wb,
  output logic [2:0] wb_addr,
  output logic [2:0] wb_data,
  output logic       mem_read,
  output logic [2:0] mem_addr,
  output logic [2:0] done,
  output logic [2:0] done_data,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, BCAST, SNOOP, WB, MEM, DONE} state_t;
  localparam logic [1:0] READ_MISS = 2'b01;
  localparam logic [1:0] NO_MSG    = 2'b11;
  localparam int CW = 8;
  state_t state_q, state_d;
  logic [1:0] ptr_q, ptr_d, own_q, own_d, msg_q, msg_d;
  logic [2:0] tag_q, tag_d, snp_data_q, snp_data_d, fill_q, fill_d;
  logic snp_hit_q, snp_hit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] pick;
  logic [2:0] snp_mask, snp_sel;
  logic [2:0] grant_q, grant_d, bus_addr_q, bus_addr_d, wb_addr_q, wb_addr_d;
  logic [2:0] wb_data_q, wb_data_d, mem_addr_q, mem_addr_d;
  logic [2:0] done_q, done_d, done_data_q, done_data_d;
  logic [1:0] bus_msg_q, bus_msg_d, bus_src_q, bus_src_d;
  logic bus_valid_q, bus_valid_d, wb_q, wb_d, mem_read_q, mem_read_d, busy_q, busy_d;
  // Descending scan so the smallest offset from the pointer / lowest receptor index wins.
  always_comb begin
    pick = ptr_q;
    for (int i = 2; i >= 0; i--)
      if (req[(int'(ptr_q) + i) % 3]) pick = 2'((int'(ptr_q) + i) % 3);
    snp_mask = snoop_wb & ~(3'b001 << own_q);
    snp_sel = 3'b000;
    for (int i = 2; i >= 0; i--)
      if (snp_mask[i]) snp_sel = snoop_wb_data[3*i +: 3];
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    own_d = own_q;
    msg_d = msg_q;
    tag_d = tag_q;
    snp_hit_d = snp_hit_q;
    snp_data_d = snp_data_q;
    fill_d = fill_q;
    cnt_d = cnt_q + CW'(1);
    case (state_q)
      IDLE: if (|req) begin
        own_d = pick;
        msg_d = msg_in[2*pick +: 2];
        tag_d = addr_in[3*pick +: 3];
        ptr_d = pick == 2'd2 ? 2'd0 : pick + 2'd1;
        snp_hit_d = 1'b0;
        snp_data_d = 3'b000;
        fill_d = 3'b000;
        state_d = msg_d == NO_MSG ? DONE : BCAST;
      end
      BCAST: begin
        cnt_d = '0;
        state_d = SNOOP;
      end
      SNOOP: begin
        if (!snp_hit_q && |snp_mask) begin
          snp_hit_d = 1'b1;
          snp_data_d = snp_sel;
        end
        if (cnt_q == CW'(SNOOP_CYCLES - 1)) begin
          cnt_d = '0;
          state_d = snp_hit_d ? WB : msg_q == READ_MISS ? MEM : DONE;
        end
      end
      WB: begin
        fill_d = msg_q == READ_MISS ? snp_data_q : fill_q;
        state_d = DONE;
      end
      MEM: if (cnt_q == CW'(MEM_LATENCY - 1)) begin
        fill_d = mem_rdata;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered images of the state being entered.
    grant_d = state_d == IDLE ? 3'b000 : 3'b001 << own_d;
    busy_d = state_d != IDLE;
    bus_valid_d = state_d == BCAST;
    bus_msg_d = bus_valid_d ? msg_d : 2'b00;
    bus_addr_d = bus_valid_d ? tag_d : 3'b000;
    bus_src_d = bus_valid_d ? own_d : 2'b00;
    wb_d = state_d == WB;
    wb_addr_d = wb_d ? tag_d : 3'b000;
    wb_data_d = wb_d ? snp_data_d : 3'b000;
    mem_read_d = state_d == MEM && state_q != MEM;
    mem_addr_d = mem_read_d ? tag_d : 3'b000;
    done_d = state_d == DONE ? 3'b001 << own_d : 3'b000;
    done_data_d = state_d == DONE && msg_d == READ_MISS ? fill_d : 3'b000;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      own_q <= '0;
      msg_q <= '0;
      tag_q <= '0;
      snp_hit_q <= 1'b0;
      snp_data_q <= '0;
      fill_q <= '0;
      cnt_q <= '0;
      grant_q <= '0;
      busy_q <= 1'b0;
      bus_valid_q <= 1'b0;
      bus_msg_q <= '0;
      bus_addr_q <= '0;
      bus_src_q <= '0;
      wb_q <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      mem_read_q <= 1'b0;
      mem_addr_q <= '0;
      done_q <= '0;
      done_data_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      own_q <= own_d;
      msg_q <= msg_d;
      tag_q <= tag_d;
      snp_hit_q <= snp_hit_d;
      snp_data_q <= snp_data_d;
      fill_q <= fill_d;
      cnt_q <= cnt_d;
      grant_q <= grant_d;
      busy_q <= busy_d;
      bus_valid_q <= bus_valid_d;
      bus_msg_q <= bus_msg_d;
      bus_addr_q <= bus_addr_d;
      bus_src_q <= bus_src_d;
      wb_q <= wb_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      mem_read_q <= mem_read_d;
      mem_addr_q <= mem_addr_d;
      done_q <= done_d;
      done_data_q <= done_data_d;
    end
  end
  assign grant = grant_q;
  assign busy = busy_q;
  assign bus_valid = bus_valid_q;
  assign bus_msg = bus_msg_q;
  assign bus_addr = bus_addr_q;
  assign bus_src = bus_src_q;
  assign wb = wb_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;
  assign mem_read = mem_read_q;
  assign mem_addr = mem_addr_q;
  assign done = done_q;
  assign done_data = done_data_q;
endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// tb_snoop_bus_arbiter: random and directed traffic checked every cycle against a
// transaction-timeline reference model of the bus arbiter.
module tb_snoop_bus_arbiter;
  localparam int S = 2, L = 4;
  logic clock = 1'b0, reset;
  logic [2:0] req, snoop_wb, mem_rdata, grant, bus_addr, wb_addr, wb_data, mem_addr, done, done_data;
  logic [5:0] msg_in;
  logic [8:0] addr_in, snoop_wb_data;
  logic [1:0] bus_msg, bus_src;
  logic bus_valid, wb, mem_read, busy;
  snoop_bus_arbiter #(.SNOOP_CYCLES(S), .MEM_LATENCY(L)) dut (
    .clock(clock), .reset(reset), .req(req), .msg_in(msg_in), .addr_in(addr_in),
    .snoop_wb(snoop_wb), .snoop_wb_data(snoop_wb_data), .mem_rdata(mem_rdata),
    .grant(grant), .bus_valid(bus_valid), .bus_msg(bus_msg), .bus_addr(bus_addr),
    .bus_src(bus_src), .wb(wb), .wb_addr(wb_addr), .wb_data(wb_data),
    .mem_read(mem_read), .mem_addr(mem_addr), .done(done), .done_data(done_data), .busy(busy)
  );
  always #5 clock = ~clock;
  int n_cmp = 0, n_bad = 0;
  // Requester side: pending requests with their message/tag, owner drop, forced re-raise.
  logic [2:0] pend = '0, drop = '0, keep = '0;
  logic [1:0] pmsg [3];
  logic [2:0] paddr [3];
  logic [2:0] snp_at [8];
  logic [8:0] snpd_at [8];
  bit auto_on = 1'b0, rst_force = 1'b0;
  // Model: t = cycle number inside the current transaction (0 = idle), d_cyc = done cycle.
  int t = 0, d_cyc = -1, own = 0, ptr = 0;
  logic [1:0] m = '0;
  logic [2:0] tag = '0, sdata = '0, fill = '0;
  bit hit = 1'b0;
  task automatic check(input string tag_s, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", tag_s, got, exp, t, $time);
    end
  endtask
  task automatic check_cycle();
    logic [2:0] g;
    g = t != 0 ? 3'(1 << own) : 3'b000;
    check("grant", 8'(grant), 8'(g));
    check("busy", 8'(busy), 8'(t != 0));
    check("bus_valid", 8'(bus_valid), 8'(t == 1 && m != 2'b11));
    if (t == 1 && m != 2'b11) begin
      check("bus_msg", 8'(bus_msg), 8'(m));
      check("bus_addr", 8'(bus_addr), 8'(tag));
      check("bus_src", 8'(bus_src), 8'(own));
    end
    check("wb", 8'(wb), 8'(t == S + 2 && hit));
    if (t == S + 2 && hit) begin
      check("wb_addr", 8'(wb_addr), 8'(tag));
      check("wb_data", 8'(wb_data), 8'(sdata));
    end
    check("mem_read", 8'(mem_read), 8'(t == S + 2 && !hit && m == 2'b01));
    if (t == S + 2 && !hit && m == 2'b01) check("mem_addr", 8'(mem_addr), 8'(tag));
    check("done", 8'(done), 8'(t != 0 && t == d_cyc ? g : 3'b000));
    if (t != 0 && t == d_cyc) check("done_data", 8'(done_data), 8'(m == 2'b01 ? fill : 3'b000));
  endtask
  task automatic step();
    logic [2:0] mask;
    check_cycle();
    if (t != 0 && t == d_cyc) begin
      pend[own] = 1'b0;
      drop[own] = 1'b0;
    end
    pend |= keep;
    if (auto_on) begin
      for (int p = 0; p < 3; p++)
        if (!pend[p] && $urandom_range(0, 3) == 0) begin
          pend[p] = 1'b1;
          pmsg[p] = 2'($urandom_range(0, 3));
          paddr[p] = 3'($urandom);
        end
      if (t >= 2 && t < d_cyc && $urandom_range(0, 7) == 0) drop[own] = 1'b1;
      snoop_wb = $urandom_range(0, 2) == 0 ? 3'($urandom) : 3'b000;
      snoop_wb_data = 9'($urandom);
    end else begin
      snoop_wb = t < 8 ? snp_at[t] : 3'b000;
      snoop_wb_data = t < 8 ? snpd_at[t] : 9'h000;
    end
    reset = rst_force || (auto_on && $urandom_range(0, 299) == 0);
    if (reset) begin
      pend = '0;
      drop = '0;
    end
    for (int p = 0; p < 3; p++) begin
      req[p] = pend[p] && !drop[p];
      msg_in[2*p +: 2] = pend[p] ? pmsg[p] : 2'($urandom);
      addr_in[3*p +: 3] = pend[p] ? paddr[p] : 3'($urandom);
    end
    if (reset) begin
      t = 0;
      ptr = 0;
      d_cyc = -1;
    end else if (t == 0) begin
      if (req != 3'b000) begin
        for (int i = 0; i < 3; i++)
          if (req[(ptr + i) % 3]) begin
            own = (ptr + i) % 3;
            break;
          end
        ptr = (own + 1) % 3;
        m = pmsg[own];
        tag = paddr[own];
        hit = 1'b0;
        fill = 3'b000;
        d_cyc = m == 2'b11 ? 1 : 1000;
        if (auto_on) mem_rdata = 3'($urandom);
        t = 1;
      end
    end else if (t == d_cyc) begin
      t = 0;
      d_cyc = -1;
    end else begin
      if (t >= 2 && t <= S + 1) begin
        mask = snoop_wb & ~(3'b001 << own);
        if (!hit && mask != 3'b000) begin
          hit = 1'b1;
          for (int i = 2; i >= 0; i--) if (mask[i]) sdata = snoop_wb_data[3*i +: 3];
          if (m == 2'b01) fill = sdata;
        end
        if (t == S + 1) d_cyc = hit ? S + 3 : (m == 2'b01 ? S + 2 + L : S + 2);
      end
      if (t == S + 1 + L && !hit && m == 2'b01) fill = mem_rdata;
      t++;
    end
  endtask
  task automatic tick();
    @(negedge clock);
    step();
  endtask
  task automatic run_until(input int target);
    for (int i = 0; i < 40 && t != target; i++) tick();
    if (t != target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: model t=%0d never reached %0d", t, target);
    end
  endtask
  task automatic clear_snoop();
    for (int i = 0; i < 8; i++) begin
      snp_at[i] = 3'b000;
      snpd_at[i] = 9'h000;
    end
  endtask
  task automatic go_idle();
    auto_on = 1'b0;
    pend = '0;
    drop = '0;
    keep = '0;
    clear_snoop();
    run_until(0);
    tick();
  endtask
  initial begin
    reset = 1'b1;
    req = '0;
    msg_in = '0;
    addr_in = '0;
    snoop_wb = '0;
    snoop_wb_data = '0;
    mem_rdata = '0;
    clear_snoop();
    for (int p = 0; p < 3; p++) begin
      pmsg[p] = 2'b11;
      paddr[p] = 3'b000;
    end
    tick();
    tick();
    auto_on = 1'b1;
    repeat (3000) tick();
    go_idle();
    // Read miss filled from memory.
    mem_rdata = 3'b110;
    pmsg[0] = 2'b01; paddr[0] = 3'b101; pend = 3'b001;
    tick();
    run_until(0);
    // Read miss filled by a snoop write-back from P0.
    snp_at[2] = 3'b001; snpd_at[2] = 9'b000_000_100;
    pmsg[1] = 2'b01; paddr[1] = 3'b010; pend = 3'b010;
    tick();
    run_until(0);
    // Write miss: owner's own snoop bit ignored, then P0 beats P1.
    clear_snoop();
    snp_at[2] = 3'b100; snpd_at[2] = 9'b101_000_000;
    snp_at[3] = 3'b011; snpd_at[3] = 9'b000_111_011;
    pmsg[2] = 2'b10; paddr[2] = 3'b001; pend = 3'b100;
    tick();
    run_until(0);
    clear_snoop();
    // Round-robin from a freshly reset pointer with all requesting continuously.
    rst_force = 1'b1; tick(); rst_force = 1'b0;
    for (int p = 0; p < 3; p++) pmsg[p] = 2'b11;
    keep = 3'b111; pend = 3'b111;
    repeat (10) tick();
    go_idle();
    // Reset during MEM, then P1/P2 contend with the pointer back at 0.
    pmsg[0] = 2'b01; paddr[0] = 3'b011; pend = 3'b001;
    tick();
    run_until(6);
    rst_force = 1'b1; tick(); rst_force = 1'b0;
    tick();
    pmsg[1] = 2'b10; paddr[1] = 3'b110; pmsg[2] = 2'b00; paddr[2] = 3'b111; pend = 3'b110;
    tick();
    run_until(0);
    run_until(1);
    run_until(0);
    // Owner drops req during SNOOP while P1 starts requesting.
    pmsg[0] = 2'b10; paddr[0] = 3'b100; pend = 3'b001;
    tick();
    run_until(2);
    drop[0] = 1'b1; pmsg[1] = 2'b01; paddr[1] = 3'b001; pend[1] = 1'b1;
    mem_rdata = 3'b011;
    run_until(0);
    run_until(1);
    run_until(0);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
